// File: rtl/hbs_issue_arbiter_pkg.sv
// Shared constants for the bit-fusion multiplier issue arbiter: mode codes,
// operand/result widths and the response FIFO entry width.
package hbs_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE4        = 2'b00,
    MODE8        = 2'b01,
    MODE16       = 2'b10,
    MODE_ILLEGAL = 2'b11
  } mode_e;

  localparam int OPND_W = 16;
  localparam int RES_W  = 32;
  localparam int MODE_W = 2;

  // Response entry layout, MSB first: {id, mode, err, data}.
  function automatic int rsp_entry_w(input int id_w);
    return id_w + MODE_W + 1 + RES_W;
  endfunction

endpackage

// File: rtl/hbs_issue_arbiter_if.sv
// Bundle of requester, datapath and response signals around the issue arbiter.
// master = requesters/datapath/consumer side, slave = the arbiter.
interface hbs_issue_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);
  // valid/ready: a transfer happens on a rising clk edge where valid and ready
  // are both high; the source holds valid and its payload until that edge.
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [2*NUM_REQ-1:0]  req_mode;
  logic [16*NUM_REQ-1:0] req_a;
  logic [16*NUM_REQ-1:0] req_b;
  logic [1:0]            dp_mode;
  logic [15:0]           dp_mult0;
  logic [15:0]           dp_mult1;
  logic [31:0]           dp_result;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [ID_W-1:0]       rsp_id;
  logic [1:0]            rsp_mode;
  logic [31:0]           rsp_data;
  logic                  rsp_err;

  modport master (
    output req_valid, req_mode, req_a, req_b, dp_result, rsp_ready,
    input  req_ready, dp_mode, dp_mult0, dp_mult1,
           rsp_valid, rsp_id, rsp_mode, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_mode, req_a, req_b, dp_result, rsp_ready,
    output req_ready, dp_mode, dp_mult0, dp_mult1,
           rsp_valid, rsp_id, rsp_mode, rsp_data, rsp_err
  );
endinterface

// File: rtl/hbs_issue_arbiter_rsp_fifo.sv
// Synchronous response FIFO with occupancy count; head is combinational and
// reads as zero while empty. DEPTH must be a power of two.
module hbs_rsp_fifo #(
  parameter int W     = 37,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_push,
  input  logic [W-1:0]           i_wdata,
  input  logic                   i_pop,
  output logic [W-1:0]           o_rdata,
  output logic [$clog2(DEPTH):0] o_count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [AW:0]   r_count;
  logic          w_pop;

  assign w_pop   = i_pop && (r_count != '0);
  assign o_count = r_count;
  assign o_rdata = (r_count != '0) ? r_mem[r_rd] : '0;

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr] <= i_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wr <= r_wr + AW'(1);
      if (w_pop)  r_rd <= r_rd + AW'(1);
      case ({i_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/hbs_issue_arbiter.sv
// Round-robin issue arbiter for a shared fixed-latency bit-fusion multiplier.
// Optional macro HBS_MODE_CHECK_EN flags mode 2'b11 requests as errors.
module hbs_issue_arbiter
  import hbs_ctrl_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int ID_W       = 2,
  parameter int PIPE_LAT   = 3,
  parameter int FIFO_DEPTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  hbs_issue_arbiter_if.slave bus
);
  localparam int ENTRY_W = rsp_entry_w(ID_W);
  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam int STG     = PIPE_LAT + 1;

  logic [ID_W-1:0]    r_ptr;
  logic [CNT_W-1:0]   r_inflight;
  logic [1:0]         r_dp_mode;
  logic [OPND_W-1:0]  r_dp_mult0;
  logic [OPND_W-1:0]  r_dp_mult1;
  logic [STG-1:0]     r_tag_vld;
  logic [ID_W-1:0]    r_tag_id   [STG];
  logic [1:0]         r_tag_mode [STG];
  logic               r_tag_err  [STG];

  logic [CNT_W-1:0]   w_fifo_count;
  logic               w_issue_ok;
  logic               w_grant_vld;
  logic [ID_W-1:0]    w_grant_idx;
  logic [1:0]         w_gnt_mode;
  logic [OPND_W-1:0]  w_gnt_a;
  logic [OPND_W-1:0]  w_gnt_b;
  logic               w_gnt_err;
  logic               w_push;
  logic [ENTRY_W-1:0] w_push_entry;
  logic [ENTRY_W-1:0] w_head;

  // Every accepted op owns a FIFO slot until popped, so a result can always land.
  assign w_issue_ok = rst_n && ((int'(w_fifo_count) + int'(r_inflight)) < FIFO_DEPTH);

  // Downward scans leave the lowest index above the pointer (hi) and overall (lo).
  always_comb begin
    logic          hi_vld, lo_vld;
    logic [ID_W-1:0] hi_idx, lo_idx;
    hi_vld = 1'b0; lo_vld = 1'b0; hi_idx = '0; lo_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (bus.req_valid[i]) begin
        if (i > int'(r_ptr)) begin
          hi_vld = 1'b1; hi_idx = ID_W'(i);
        end else begin
          lo_vld = 1'b1; lo_idx = ID_W'(i);
        end
      end
    end
    w_grant_vld = w_issue_ok && (hi_vld || lo_vld);
    w_grant_idx = hi_vld ? hi_idx : lo_idx;
  end

  always_comb begin
    bus.req_ready = '0;
    w_gnt_mode    = '0;
    w_gnt_a       = '0;
    w_gnt_b       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant_idx == ID_W'(i)) begin
        bus.req_ready[i] = w_grant_vld;
        w_gnt_mode       = bus.req_mode[2*i +: 2];
        w_gnt_a          = bus.req_a[16*i +: 16];
        w_gnt_b          = bus.req_b[16*i +: 16];
      end
    end
  end

`ifdef HBS_MODE_CHECK_EN
  assign w_gnt_err = (w_gnt_mode == MODE_ILLEGAL);
`else
  assign w_gnt_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr      <= ID_W'(NUM_REQ - 1);
      r_inflight <= '0;
      r_dp_mode  <= '0;
      r_dp_mult0 <= '0;
      r_dp_mult1 <= '0;
      r_tag_vld  <= '0;
      for (int s = 0; s < STG; s++) begin
        r_tag_id[s]   <= '0;
        r_tag_mode[s] <= '0;
        r_tag_err[s]  <= 1'b0;
      end
    end else begin
      if (w_grant_vld) begin
        r_ptr      <= w_grant_idx;
        r_dp_mode  <= w_gnt_err ? 2'(MODE4) : w_gnt_mode;
        r_dp_mult0 <= w_gnt_err ? '0 : w_gnt_a;
        r_dp_mult1 <= w_gnt_err ? '0 : w_gnt_b;
      end
      r_tag_vld     <= {r_tag_vld[STG-2:0], w_grant_vld};
      r_tag_id[0]   <= w_grant_idx;
      r_tag_mode[0] <= w_gnt_mode;
      r_tag_err[0]  <= w_gnt_err;
      for (int s = 1; s < STG; s++) begin
        r_tag_id[s]   <= r_tag_id[s-1];
        r_tag_mode[s] <= r_tag_mode[s-1];
        r_tag_err[s]  <= r_tag_err[s-1];
      end
      case ({w_grant_vld, w_push})
        2'b10:   r_inflight <= r_inflight + CNT_W'(1);
        2'b01:   r_inflight <= r_inflight - CNT_W'(1);
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  assign bus.dp_mode  = r_dp_mode;
  assign bus.dp_mult0 = r_dp_mult0;
  assign bus.dp_mult1 = r_dp_mult1;

  // The last tag stage lines up with the cycle dp_result holds that op's product.
  assign w_push       = r_tag_vld[STG-1];
  assign w_push_entry = {r_tag_id[STG-1], r_tag_mode[STG-1], r_tag_err[STG-1],
                         (r_tag_err[STG-1] ? {RES_W{1'b0}} : bus.dp_result)};

  hbs_rsp_fifo #(
    .W     (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_rsp_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_wdata (w_push_entry),
    .i_pop   (bus.rsp_ready),
    .o_rdata (w_head),
    .o_count (w_fifo_count)
  );

  assign bus.rsp_valid = (w_fifo_count != '0);
  assign {bus.rsp_id, bus.rsp_mode, bus.rsp_err, bus.rsp_data} = w_head;
endmodule

// File: tb/tb_hbs_issue_arbiter.sv
// Bench for hbs_issue_arbiter: directed vector table, multi-cycle sequences and
// random traffic scored against a queue-based cycle model of the arbiter.
module tb_hbs_issue_arbiter;
  import hbs_ctrl_pkg::*;

  localparam int NR    = 4;
  localparam int IDW   = 2;
  localparam int PL    = 3;
  localparam int DEPTH = 8;
  localparam int EW    = rsp_entry_w(IDW);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hbs_issue_arbiter_if #(.NUM_REQ(NR), .ID_W(IDW)) bus();

  hbs_issue_arbiter #(
    .NUM_REQ(NR), .ID_W(IDW), .PIPE_LAT(PL), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [NR-1:0] drv_valid;
  logic [1:0]    drv_mode [NR];
  logic [15:0]   drv_a    [NR];
  logic [15:0]   drv_b    [NR];
  logic          drv_rsp_ready;

  always_comb begin
    for (int i = 0; i < NR; i++) begin
      bus.req_valid[i]       = drv_valid[i];
      bus.req_mode[2*i +: 2] = drv_mode[i];
      bus.req_a[16*i +: 16]  = drv_a[i];
      bus.req_b[16*i +: 16]  = drv_b[i];
    end
    bus.rsp_ready = drv_rsp_ready;
  end

  // Lane-split product: 16b full, 8b two byte lanes, 4b four nibble lanes.
  function automatic logic [31:0] fuse_mul(input logic [1:0] m, input logic [15:0] a, input logic [15:0] b);
    logic [31:0] r;
    r = '0;
    case (m)
      2'b10: r = 32'(a) * 32'(b);
      2'b01: for (int l = 0; l < 2; l++) r[16*l +: 16] = 16'(a[8*l +: 8]) * 16'(b[8*l +: 8]);
      2'b00: for (int l = 0; l < 4; l++) r[8*l +: 8] = 8'(a[4*l +: 4]) * 8'(b[4*l +: 4]);
      default: r = '0;
    endcase
    return r;
  endfunction

  // Stand-in for the multiplier: PL register stages after sampling dp_*.
  logic [31:0] mul_pipe [PL];
  always @(posedge clk) begin
    mul_pipe[0] <= fuse_mul(bus.dp_mode, bus.dp_mult0, bus.dp_mult1);
    for (int s = 1; s < PL; s++) mul_pipe[s] <= mul_pipe[s-1];
  end
  assign bus.dp_result = mul_pipe[PL-1];

  function automatic logic mode_err(input logic [1:0] m);
`ifdef HBS_MODE_CHECK_EN
    return (m == 2'b11);
`else
    return 1'b0;
`endif
  endfunction

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Reference model: responses visible in the FIFO (exp_q) and ops still in
  // the multiplier with the model cycle at which they land.
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] fly_e[$];
  int            fly_due[$];
  int            m_cyc = 0;
  int            m_ptr = NR - 1;
  logic          mon_en = 1'b0;
  logic          last_acc = 1'b0;
  int            last_acc_id = 0;
  int            grant_log[$];
  int            pop_log[$];

  function automatic int model_pick();
    if (fly_e.size() + exp_q.size() >= DEPTH) return -1;
    for (int i = 1; i <= NR; i++) begin
      if (drv_valid[(m_ptr + i) % NR]) return (m_ptr + i) % NR;
    end
    return -1;
  endfunction

  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      int            pick;
      logic [NR-1:0] exp_rdy;
      logic          err;
      logic          pop;
      pick = model_pick();
      exp_rdy = '0;
      if (pick >= 0) exp_rdy[pick] = 1'b1;
      check("req_ready", bus.req_ready, exp_rdy);
      check("rsp_valid", bus.rsp_valid, exp_q.size() != 0);
      if (exp_q.size() != 0)
        check("rsp_head", {bus.rsp_id, bus.rsp_mode, bus.rsp_err, bus.rsp_data}, exp_q[0]);
      pop = (exp_q.size() != 0) && drv_rsp_ready;
      m_cyc++;
      if (pop) begin
        pop_log.push_back(int'(exp_q[0][EW-1 -: IDW]));
        void'(exp_q.pop_front());
      end
      while (fly_due.size() != 0 && fly_due[0] == m_cyc) begin
        exp_q.push_back(fly_e.pop_front());
        void'(fly_due.pop_front());
      end
      last_acc    = (pick >= 0);
      last_acc_id = pick;
      if (pick >= 0) begin
        err = mode_err(drv_mode[pick]);
        fly_e.push_back({IDW'(pick), drv_mode[pick], err,
                         (err ? 32'h0 : fuse_mul(drv_mode[pick], drv_a[pick], drv_b[pick]))});
        fly_due.push_back(m_cyc + PL + 1);
        m_ptr = pick;
        grant_log.push_back(pick);
      end
    end else begin
      last_acc = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int id, input logic [1:0] m, input logic [15:0] a, input logic [15:0] b);
    drv_valid[id] = 1'b1;
    drv_mode[id]  = m;
    drv_a[id]     = a;
    drv_b[id]     = b;
  endtask

  task automatic set_rand_req(input int id, input int max_mode);
    set_req(id, 2'($urandom_range(0, max_mode)), 16'($urandom), 16'($urandom));
  endtask

  typedef struct {
    int          id;
    logic [1:0]  mode;
    logic [15:0] a;
    logic [15:0] b;
    logic        exp_err;
    logic [31:0] exp_data;
  } vec_t;

  // One isolated request: accept, dp_* contents, exact latency, response fields.
  task automatic run_vec(input vec_t v);
    int   waited, lat;
    logic seen;
    drv_rsp_ready = 1'b1;
    set_req(v.id, v.mode, v.a, v.b);
    waited = 0;
    @(negedge clk);
    while (!bus.req_ready[v.id] && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    check("vec_accept", waited < 10, 1'b1);
    tick();
    drv_valid[v.id] = 1'b0;
    check("vec_dp_mode", bus.dp_mode, v.exp_err ? 2'b00 : v.mode);
    check("vec_dp_mult0", bus.dp_mult0, v.exp_err ? 16'h0 : v.a);
    check("vec_dp_mult1", bus.dp_mult1, v.exp_err ? 16'h0 : v.b);
    lat = 0;
    seen = 1'b0;
    for (int t = 0; t < 20 && !seen; t++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      seen = bus.rsp_valid;
    end
    check("vec_latency", lat, PL + 1);
    check("vec_rsp_id", bus.rsp_id, v.id);
    check("vec_rsp_mode", bus.rsp_mode, v.mode);
    check("vec_rsp_err", bus.rsp_err, v.exp_err);
    check("vec_rsp_data", bus.rsp_data, v.exp_data);
    repeat (3) tick();
  endtask

  vec_t vecs[7];
  vec_t err_vec;

  initial begin
    vecs[0] = '{0, 2'b10, 16'h1234, 16'h5678, 1'b0, 32'h0626_0060};
    vecs[1] = '{2, 2'b01, 16'h0302, 16'h0504, 1'b0, 32'h000F_0008};
    vecs[2] = '{1, 2'b00, 16'h4321, 16'h1234, 1'b0, 32'h0406_0604};
    vecs[3] = '{0, 2'b00, 16'hFFFF, 16'hFFFF, 1'b0, 32'hE1E1_E1E1};
    vecs[4] = '{2, 2'b01, 16'hFF80, 16'h02FF, 1'b0, 32'h01FE_7F80};
    vecs[5] = '{1, 2'b10, 16'h0000, 16'hBEEF, 1'b0, 32'h0000_0000};
    vecs[6] = '{3, 2'b10, 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE_0001};
    err_vec = '{1, 2'b11, 16'hABCD, 16'h1234, 1'b1, 32'h0000_0000};

    for (int i = 0; i < NR; i++) set_req(i, 2'b10, 16'h1111, 16'h2222);
    drv_valid = '1;
    drv_rsp_ready = 1'b1;
    #22;
    check("rst_req_ready", bus.req_ready, 0);
    check("rst_dp_mode", bus.dp_mode, 0);
    check("rst_dp_mult0", bus.dp_mult0, 0);
    check("rst_dp_mult1", bus.dp_mult1, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_fields", {bus.rsp_id, bus.rsp_mode, bus.rsp_err, bus.rsp_data}, 0);
    tick();
    drv_valid = '0;
    rst_n = 1'b1;
    mon_en = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);
`ifdef HBS_MODE_CHECK_EN
    run_vec(err_vec);
`endif

    // All requesters busy, consumer always ready: strict rotation, one per cycle.
    grant_log.delete(); pop_log.delete();
    for (int i = 0; i < NR; i++) set_rand_req(i, 2);
    repeat (16) begin
      tick();
      if (last_acc) set_rand_req(last_acc_id, 2);
    end
    drv_valid = '0;
    repeat (PL + 4) tick();
    check("rr_count", grant_log.size(), 16);
    for (int i = 0; i < grant_log.size(); i++) check("rr_order", grant_log[i], i % NR);
    check("rr_pop_count", pop_log.size(), grant_log.size());
    for (int i = 0; i < pop_log.size() && i < grant_log.size(); i++) check("rr_rsp_id", pop_log[i], grant_log[i]);

    // Consumer stalled: credit stops issue at exactly FIFO_DEPTH, then drains in order.
    grant_log.delete(); pop_log.delete();
    drv_rsp_ready = 1'b0;
    for (int i = 0; i < NR; i++) set_rand_req(i, 2);
    repeat (20) begin
      tick();
      if (last_acc) set_rand_req(last_acc_id, 2);
    end
    check("bp_accepts", grant_log.size(), DEPTH);
    check("bp_ready_low", bus.req_ready, 0);
    drv_valid = '0;
    drv_rsp_ready = 1'b1;
    repeat (DEPTH + 4) tick();
    check("bp_drain_count", pop_log.size(), DEPTH);
    for (int i = 0; i < pop_log.size() && i < grant_log.size(); i++) check("bp_drain_order", pop_log[i], grant_log[i]);

    // Reset with results both queued and in flight.
    drv_rsp_ready = 1'b0;
    for (int i = 1; i < NR; i++) set_rand_req(i, 2);
    repeat (3) tick();
    drv_valid = '0;
    repeat (PL + 2) tick();
    check("mid_fifo_loaded", bus.rsp_valid, 1'b1);
    for (int i = 1; i < NR; i++) set_rand_req(i, 2);
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    check("mid_rst_rsp_valid", bus.rsp_valid, 0);
    check("mid_rst_req_ready", bus.req_ready, 0);
    check("mid_rst_dp", {bus.dp_mode, bus.dp_mult0, bus.dp_mult1}, 0);
    exp_q.delete(); fly_e.delete(); fly_due.delete();
    m_ptr = NR - 1;
    drv_valid = '0;
    tick();
    tick();
    rst_n = 1'b1;
    drv_rsp_ready = 1'b1;
    repeat (10) tick();
    for (int i = 0; i < NR; i++) set_rand_req(i, 2);
    @(negedge clk);
    #1;
    check("post_rst_first_grant", bus.req_ready, 4'b0001);
    tick();
    drv_valid = '0;
    repeat (PL + 4) tick();

    // Random traffic, requests held until accepted, random consumer stalls.
    repeat (500) begin
      tick();
      drv_rsp_ready = ($urandom_range(0, 9) < 7);
      if (last_acc) drv_valid[last_acc_id] = 1'b0;
      for (int i = 0; i < NR; i++)
        if (!drv_valid[i] && $urandom_range(0, 1) == 1) set_rand_req(i, 3);
    end
    drv_valid = '0;
    drv_rsp_ready = 1'b1;
    repeat (DEPTH + PL + 6) tick();
    check("final_drained", exp_q.size() + fly_e.size(), 0);
    check("final_rsp_valid", bus.rsp_valid, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    n_errors++;
    $display("FAIL timeout got=running exp=finished");
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $fatal(1, "bench timeout");
  end
endmodule
